// File: rtl/caesar_pkg.sv
// Shared constants and types for the single-character Caesar cipher engine.
package caesar_pkg;
    localparam int         ALPHA_LEN     = 26;
    localparam logic [5:0] ALPHA_LEN6    = 6'd26;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_QMARK   = 8'h3F;

    typedef logic [4:0] alpha_idx_t;
endpackage

// File: rtl/onehot26_enc.sv
// 26-bit select vector to index encoder: lowest set bit wins, plus "any" and "exactly one" flags.
module onehot26_enc
    import caesar_pkg::*;
(
    input  logic [ALPHA_LEN-1:0] vec_i,
    output alpha_idx_t           idx_o,
    output logic                 any_o,
    output logic                 onehot_ok_o
);

    // Scan from the top so the lowest asserted index is the last (winning) write.
    always_comb begin
        idx_o = '0;
        for (int i = ALPHA_LEN - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = alpha_idx_t'(i);
            end
        end
    end

    assign any_o       = |vec_i;
    assign onehot_ok_o = any_o && ((vec_i & (vec_i - 26'd1)) == '0);

endmodule

// File: rtl/caesar_cipher_gm.sv
// Registered single-character Caesar cipher: one-hot letter and shift in, ASCII letter out.
// Optional macro ONEHOT_CHECK_EN: non-one-hot selects register '?' instead of lowest-bit-wins.
module caesar_cipher_gm
    import caesar_pkg::*;
#(
    parameter logic [7:0] RESET_CHAR = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a, b, c, d, e, f, g, h, i, j, k, l, m,
    input  logic       n, o, p, q, r, s, t, u, v, w, x, y, z,
    input  logic       i1, i2, i3, i4, i5, i6, i7, i8, i9, i10, i11, i12, i13,
    input  logic       i14, i15, i16, i17, i18, i19, i20, i21, i22, i23, i24, i25, i26,
    input  logic       cap,
    input  logic       en,
    output logic [0:7] out
);

    logic [ALPHA_LEN-1:0] letter_vec;
    logic [ALPHA_LEN-1:0] shift_vec;
    alpha_idx_t           letter_idx;
    alpha_idx_t           shift_idx;
    logic                 shift_any;
    logic [5:0]           letter6;
    logic [5:0]           shift6;
    logic [5:0]           sum_raw;
    logic [5:0]           rot;
    logic [7:0]           char_d;
    logic [7:0]           char_q;

    assign letter_vec = {z, y, x, w, v, u, t, s, r, q, p, o, n,
                         m, l, k, j, i, h, g, f, e, d, c, b, a};
    assign shift_vec  = {i26, i25, i24, i23, i22, i21, i20, i19, i18, i17, i16, i15, i14,
                         i13, i12, i11, i10, i9, i8, i7, i6, i5, i4, i3, i2, i1};

`ifdef ONEHOT_CHECK_EN
    logic letter_ok;
    logic shift_ok;
`endif

    onehot26_enc u_letter_enc (
        .vec_i       (letter_vec),
        .idx_o       (letter_idx),
        .any_o       (),
`ifdef ONEHOT_CHECK_EN
        .onehot_ok_o (letter_ok)
`else
        .onehot_ok_o ()
`endif
    );

    onehot26_enc u_shift_enc (
        .vec_i       (shift_vec),
        .idx_o       (shift_idx),
        .any_o       (shift_any),
`ifdef ONEHOT_CHECK_EN
        .onehot_ok_o (shift_ok)
`else
        .onehot_ok_o ()
`endif
    );

    // Shift bit k means shift k+1; an empty shift select is the identity shift of 26.
    assign letter6 = {1'b0, letter_idx};
    assign shift6  = shift_any ? ({1'b0, shift_idx} + 6'd1) : ALPHA_LEN6;

    // Decrypt adds 26 first so the 6-bit intermediate never goes negative (range 0..50).
    assign sum_raw = en ? (letter6 + ALPHA_LEN6 - shift6) : (letter6 + shift6);
    assign rot     = (sum_raw >= ALPHA_LEN6) ? (sum_raw - ALPHA_LEN6) : sum_raw;

    always_comb begin
        char_d = (cap ? ASCII_UPPER_A : ASCII_LOWER_A) + {2'b00, rot};
`ifdef ONEHOT_CHECK_EN
        if (!(letter_ok && shift_ok)) begin
            char_d = ASCII_QMARK;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_q <= RESET_CHAR;
        end else begin
            char_q <= char_d;
        end
    end

    // out is declared [0:7]; value assignment puts char_q[7] on out[0], the MSB.
    assign out = char_q;

endmodule

// File: tb/tb_caesar_cipher_gm.sv
// Bench for caesar_cipher_gm: directed cases, invalid selects, async reset, exhaustive and random sweeps.
module tb_caesar_cipher_gm;

    logic        clk;
    logic        rst_n;
    logic [25:0] let_v;
    logic [25:0] sh_v;
    logic        cap;
    logic        en;
    logic [0:7]  out;

    int total;
    int bad;
    logic [7:0] exp_q[$];

    caesar_cipher_gm #(.RESET_CHAR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(let_v[0]),  .b(let_v[1]),  .c(let_v[2]),  .d(let_v[3]),  .e(let_v[4]),
        .f(let_v[5]),  .g(let_v[6]),  .h(let_v[7]),  .i(let_v[8]),  .j(let_v[9]),
        .k(let_v[10]), .l(let_v[11]), .m(let_v[12]), .n(let_v[13]), .o(let_v[14]),
        .p(let_v[15]), .q(let_v[16]), .r(let_v[17]), .s(let_v[18]), .t(let_v[19]),
        .u(let_v[20]), .v(let_v[21]), .w(let_v[22]), .x(let_v[23]), .y(let_v[24]),
        .z(let_v[25]),
        .i1(sh_v[0]),   .i2(sh_v[1]),   .i3(sh_v[2]),   .i4(sh_v[3]),   .i5(sh_v[4]),
        .i6(sh_v[5]),   .i7(sh_v[6]),   .i8(sh_v[7]),   .i9(sh_v[8]),   .i10(sh_v[9]),
        .i11(sh_v[10]), .i12(sh_v[11]), .i13(sh_v[12]), .i14(sh_v[13]), .i15(sh_v[14]),
        .i16(sh_v[15]), .i17(sh_v[16]), .i18(sh_v[17]), .i19(sh_v[18]), .i20(sh_v[19]),
        .i21(sh_v[20]), .i22(sh_v[21]), .i23(sh_v[22]), .i24(sh_v[23]), .i25(sh_v[24]),
        .i26(sh_v[25]),
        .cap(cap), .en(en), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: letters are alphabet positions, shifts are counts 1..26, plain modulo arithmetic.
    function automatic logic [7:0] ref_char(input logic [25:0] lv, input logic [25:0] sv,
                                            input logic cp, input logic dec);
        int lt, sh, rr;
        lt = 0;
        sh = 26;
        for (int idx = 25; idx >= 0; idx--) if (lv[idx]) lt = idx;
        for (int idx = 25; idx >= 0; idx--) if (sv[idx]) sh = idx + 1;
        if (dec) rr = (lt - sh + 26) % 26;
        else     rr = (lt + sh) % 26;
`ifdef ONEHOT_CHECK_EN
        if ($countones(lv) != 1 || $countones(sv) != 1) return 8'h3F;
`endif
        return (cp ? 8'd65 : 8'd97) + 8'(rr);
    endfunction

    function automatic logic [25:0] onehot(input int pos);
        logic [25:0] vv;
        vv = '0;
        if (pos >= 0 && pos < 26) vv[pos] = 1'b1;
        return vv;
    endfunction

    // Apply inputs at the falling edge, then wait past the next rising edge.
    task automatic drive_vec(input logic [25:0] lv, input logic [25:0] sv,
                             input logic cp, input logic dec);
        @(negedge clk);
        let_v = lv;
        sh_v  = sv;
        cap   = cp;
        en    = dec;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        let_v = 26'($urandom);
        sh_v  = 26'($urandom);
        cap   = 1'($urandom);
        en    = 1'($urandom);
        #1;
        total++;
        if (out !== 8'h00) begin
            bad++;
            $display("FAIL reset_immediate: got %h want 00", out);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out !== 8'h00) begin
            bad++;
            $display("FAIL reset_held: got %h want 00", out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        let_v = onehot(0);
        sh_v  = onehot(5);
        cap   = 1'b0;
        en    = 1'b0;
        #1;
        total++;
        if (out !== 8'h00) begin
            bad++;
            $display("FAIL reset_release_no_edge: got %h want 00", out);
        end
        @(posedge clk);
        #1;
        total++;
        if (out !== 8'h67) begin
            bad++;
            $display("FAIL first_edge_a_i6: got %h want 67", out);
        end
    endtask

    task automatic test_encrypt();
        drive_vec(onehot(2), onehot(9), 1'b0, 1'b0);
        total++;
        if (out !== 8'h6D) begin
            bad++;
            $display("FAIL enc_c_i10: got %h want 6d", out);
        end
        drive_vec(onehot(25), onehot(25), 1'b1, 1'b0);
        total++;
        if (out !== 8'h5A) begin
            bad++;
            $display("FAIL enc_z_i26_cap: got %h want 5a", out);
        end
    endtask

    task automatic test_decrypt();
        drive_vec(onehot(10), onehot(7), 1'b0, 1'b1);
        total++;
        if (out !== 8'h63) begin
            bad++;
            $display("FAIL dec_k_i8: got %h want 63", out);
        end
        drive_vec(onehot(0), onehot(25), 1'b0, 1'b1);
        total++;
        if (out !== 8'h61) begin
            bad++;
            $display("FAIL dec_a_i26: got %h want 61", out);
        end
        drive_vec(onehot(22), onehot(3), 1'b1, 1'b1);
        total++;
        if (out !== 8'h53) begin
            bad++;
            $display("FAIL dec_w_i4_cap: got %h want 53", out);
        end
        drive_vec(onehot(3), onehot(8), 1'b1, 1'b1);
        total++;
        if (out !== 8'h55) begin
            bad++;
            $display("FAIL dec_d_i9_cap_wrap: got %h want 55", out);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] want;
        drive_vec(26'b11, onehot(0), 1'b0, 1'b0);
`ifdef ONEHOT_CHECK_EN
        want = 8'h3F;
`else
        want = 8'h62;
`endif
        total++;
        if (out !== want) begin
            bad++;
            $display("FAIL invalid_ab_i1: got %h want %h", out, want);
        end
        drive_vec('0, onehot(2), 1'b0, 1'b0);
`ifdef ONEHOT_CHECK_EN
        want = 8'h3F;
`else
        want = 8'h64;
`endif
        total++;
        if (out !== want) begin
            bad++;
            $display("FAIL invalid_no_letter_i3: got %h want %h", out, want);
        end
        drive_vec(onehot(2), '0, 1'b1, 1'b1);
`ifdef ONEHOT_CHECK_EN
        want = 8'h3F;
`else
        want = 8'h43;
`endif
        total++;
        if (out !== want) begin
            bad++;
            $display("FAIL invalid_no_shift_c: got %h want %h", out, want);
        end
    endtask

    task automatic test_async_reset();
        drive_vec(onehot(22), onehot(3), 1'b1, 1'b1);
        total++;
        if (out !== 8'h53) begin
            bad++;
            $display("FAIL async_pre_S: got %h want 53", out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out !== 8'h00) begin
            bad++;
            $display("FAIL async_reset_midcycle: got %h want 00", out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out !== 8'h53) begin
            bad++;
            $display("FAIL async_recover: got %h want 53", out);
        end
    endtask

    // Back-to-back: a new input every cycle, each result checked one cycle later.
    task automatic test_sweep();
        logic [7:0] want;
        exp_q.delete();
        for (int li = 0; li < 26; li++) begin
            for (int sn = 1; sn <= 26; sn++) begin
                for (int md = 0; md < 4; md++) begin
                    @(negedge clk);
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        total++;
                        if (out !== want) begin
                            bad++;
                            $display("FAIL sweep: got %h want %h", out, want);
                        end
                    end
                    let_v = onehot(li);
                    sh_v  = onehot(sn - 1);
                    cap   = md[0];
                    en    = md[1];
                    exp_q.push_back(ref_char(let_v, sh_v, cap, en));
                end
            end
        end
        @(negedge clk);
        want = exp_q.pop_front();
        total++;
        if (out !== want) begin
            bad++;
            $display("FAIL sweep_last: got %h want %h", out, want);
        end
    endtask

    task automatic test_random();
        logic [25:0] lv, sv;
        logic        cp, dec;
        logic [7:0]  want;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0, 1:    lv = onehot(int'($urandom_range(0, 25)));
                2:       lv = '0;
                default: lv = 26'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1:    sv = onehot(int'($urandom_range(0, 25)));
                2:       sv = '0;
                default: sv = 26'($urandom);
            endcase
            cp  = 1'($urandom);
            dec = 1'($urandom);
            want = ref_char(lv, sv, cp, dec);
            drive_vec(lv, sv, cp, dec);
            total++;
            if (out !== want) begin
                bad++;
                $display("FAIL random: letters=%h shifts=%h cap=%b en=%b got %h want %h",
                         lv, sv, cp, dec, out, want);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        let_v = '0;
        sh_v  = '0;
        cap   = 1'b0;
        en    = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_invalid();
        test_async_reset();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
